regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 122 ++++++++++++
 tb/tb_regfile_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Two-write, two-read register file with a self-clearing start-up sequencer,
// a stack-pointer preset, a hardwired zero register and a memory-mapped I/O slot.
module regfile_param #(
    parameter int unsigned       DATA_W  = 32,
    parameter int unsigned       ADDR_W  = 5,
    parameter int unsigned       SP_ADDR = 29,
    parameter logic [DATA_W-1:0] SP_INIT = 32'h7fffeffc,
    parameter int unsigned       IO_ADDR = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] writeaddr0,
    input  logic [ADDR_W-1:0] writeaddr1,
    input  logic [DATA_W-1:0] writedata0,
    input  logic [DATA_W-1:0] writedata1,
    input  logic [ADDR_W-1:0] readaddr1,
    input  logic [ADDR_W-1:0] readaddr2,
    output logic [DATA_W-1:0] readdata1,
    output logic [DATA_W-1:0] readdata2,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out,
    output logic              io_out_valid,
    output logic              ready
);
    localparam int unsigned       DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] SP_A  = ADDR_W'(SP_ADDR);
    localparam logic [ADDR_W-1:0] IO_A  = ADDR_W'(IO_ADDR);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {StClear, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic run;
    logic wr0_ok, wr1_ok, io_wr0, io_wr1;

    assign run    = (state_q == StRun);
    assign io_wr1 = we1 && (writeaddr1 == IO_A);
    assign io_wr0 = we0 && (writeaddr0 == IO_A);
    assign wr1_ok = we1 && (writeaddr1 != '0) && (writeaddr1 != IO_A);
    // Port 1 wins a same-address collision, so port 0 is suppressed outright.
    assign wr0_ok = we0 && (writeaddr0 != '0) && (writeaddr0 != IO_A)
                    && !(we1 && (writeaddr1 == writeaddr0));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StClear;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClear: if (clr_idx_q == LAST) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StClear;
        endcase
    end

    // Output logic
    always_comb begin
        ready = 1'b0;
        unique case (state_q)
            StClear: ready = 1'b0;
            StRun:   ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx_q    <= ADDR_W'(1);
            io_out       <= '0;
            io_out_valid <= 1'b0;
        end else begin
            io_out_valid <= 1'b0;
            if (!run) begin
                clr_idx_q <= clr_idx_q + ADDR_W'(1);
            end else if (io_wr1) begin
                io_out       <= writedata1;
                io_out_valid <= 1'b1;
            end else if (io_wr0) begin
                io_out       <= writedata0;
                io_out_valid <= 1'b1;
            end
        end
    end

    // Entry 0 is never written; its reads are forced to zero instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                mem[clr_idx_q] <= (clr_idx_q == SP_A) ? SP_INIT : '0;
            end else begin
                if (wr0_ok) mem[writeaddr0] <= writedata0;
                if (wr1_ok) mem[writeaddr1] <= writedata1;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] r;
        if (!run || a == '0)             r = '0;
        else if (a == IO_A)              r = io_in;
        else if (we1 && writeaddr1 == a) r = writedata1;
        else if (we0 && writeaddr0 == a) r = writedata0;
        else                             r = mem[a];
        return r;
    endfunction

    assign readdata1 = read_port(readaddr1);
    assign readdata2 = read_port(readaddr2);

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed clear/reset sequences, a vector
// table for the RUN-mode read/write rules, then randomized traffic against a model.
module tb_regfile_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [4:0]  writeaddr0 = '0, writeaddr1 = '0, readaddr1 = '0, readaddr2 = '0;
    logic [31:0] writedata0 = '0, writedata1 = '0, io_in = '0;
    logic [31:0] readdata1, readdata2, io_out;
    logic        io_out_valid, ready;

    int n_chk = 0;
    int n_pass = 0;

    regfile_param dut (
        .clk(clk), .rst(rst), .we0(we0), .we1(we1),
        .writeaddr0(writeaddr0), .writeaddr1(writeaddr1),
        .writedata0(writedata0), .writedata1(writedata1),
        .readaddr1(readaddr1), .readaddr2(readaddr2),
        .readdata1(readdata1), .readdata2(readdata2),
        .io_in(io_in), .io_out(io_out), .io_out_valid(io_out_valid), .ready(ready)
    );

    always #5 clk = ~clk;

    // Reference model: cycles of clearing still owed, a plain array, and the I/O register.
    logic [31:0] m_mem [32];
    int          m_clr_left = 31;
    logic [31:0] m_io = '0;
    logic        m_iov = 1'b0;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (m_clr_left > 0) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (a == 5'd30) return io_in;
        if (we1 && writeaddr1 == a) return writedata1;
        if (we0 && writeaddr0 == a) return writedata0;
        return m_mem[a];
    endfunction

    task automatic model_step();
        if (rst) begin
            m_clr_left = 31;
            m_io = '0;
            m_iov = 1'b0;
            for (int i = 0; i < 32; i++) m_mem[i] = (i == 29) ? 32'h7fffeffc : 32'h0;
        end else if (m_clr_left > 0) begin
            m_clr_left--;
            m_iov = 1'b0;
        end else begin
            m_iov = 1'b0;
            if (we0 && writeaddr0 != 5'd0 && writeaddr0 != 5'd30) m_mem[writeaddr0] = writedata0;
            if (we1 && writeaddr1 != 5'd0 && writeaddr1 != 5'd30) m_mem[writeaddr1] = writedata1;
            if (we1 && writeaddr1 == 5'd30) begin
                m_io = writedata1; m_iov = 1'b1;
            end else if (we0 && writeaddr0 == 5'd30) begin
                m_io = writedata0; m_iov = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0;
    endtask

    // Counts edges after rst release until ready; gives up after a bound.
    task automatic count_to_ready(input string name);
        int n = 0;
        rst = 1'b0;
        idle();
        while (n < 100) begin
            tick();
            n++;
            if (ready) break;
        end
        chk(name, n, 31);
    endtask

    typedef struct {
        logic we0, we1;
        logic [4:0] wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [4:0] ra1, ra2;
        logic [31:0] ioin, e_rd1, e_rd2, e_io;
        logic e_iov;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [4:0] rand_addr();
        case ($urandom_range(0, 5))
            0: return 5'd0;
            1: return 5'd29;
            2: return 5'd30;
            3: return 5'($urandom_range(1, 3));
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 5'd7,  5'd0,  32'h1234, 32'h0,    5'd7,  5'd0,  32'h0,
                    32'h1234, 32'h0,        32'h0,    1'b0};
        tbl[1]  = '{1'b0, 1'b0, 5'd0,  5'd0,  32'h0,    32'h0,    5'd7,  5'd29, 32'h0,
                    32'h1234, 32'h7fffeffc, 32'h0,    1'b0};
        tbl[2]  = '{1'b1, 1'b1, 5'd9,  5'd9,  32'hA,    32'hB,    5'd9,  5'd9,  32'h0,
                    32'hB,    32'hB,        32'h0,    1'b0};
        tbl[3]  = '{1'b0, 1'b0, 5'd0,  5'd0,  32'h0,    32'h0,    5'd9,  5'd7,  32'h0,
                    32'hB,    32'h1234,     32'h0,    1'b0};
        tbl[4]  = '{1'b1, 1'b0, 5'd0,  5'd0,  32'hFFFF, 32'h0,    5'd0,  5'd0,  32'h0,
                    32'h0,    32'h0,        32'h0,    1'b0};
        tbl[5]  = '{1'b0, 1'b0, 5'd0,  5'd0,  32'h0,    32'h0,    5'd0,  5'd3,  32'h0,
                    32'h0,    32'h0,        32'h0,    1'b0};
        tbl[6]  = '{1'b1, 1'b0, 5'd30, 5'd0,  32'hDEAD, 32'h0,    5'd30, 5'd30, 32'h55,
                    32'h55,   32'h55,       32'hDEAD, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 5'd0,  5'd0,  32'h0,    32'h0,    5'd30, 5'd9,  32'h55,
                    32'h55,   32'hB,        32'hDEAD, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 5'd14, 5'd13, 32'h1111, 32'h2222, 5'd13, 5'd14, 32'h0,
                    32'h2222, 32'h1111,     32'hDEAD, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 5'd0,  5'd0,  32'h0,    32'h0,    5'd13, 5'd14, 32'h0,
                    32'h2222, 32'h1111,     32'hDEAD, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 5'd30, 5'd30, 32'hAAAA, 32'hBBBB, 5'd0,  5'd30, 32'h66,
                    32'h0,    32'h66,       32'hBBBB, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 5'd0,  5'd0,  32'h0,    32'h0,    5'd30, 5'd0,  32'h66,
                    32'h66,   32'h0,        32'hBBBB, 1'b0};

        // Reset state
        tick();
        tick();
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_io_out", io_out, 32'h0);
        chk("rst_io_valid", {31'b0, io_out_valid}, 32'h0);
        readaddr1 = 5'd29;
        #1;
        chk("rst_read_zero", readdata1, 32'h0);

        // Clear sequence with a write to 3 attempted mid-clear
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        we0 = 1'b1; writeaddr0 = 5'd3; writedata0 = 32'hBAD; readaddr1 = 5'd3;
        #1;
        chk("clear_read_zero", readdata1, 32'h0);
        tick();
        chk("clear_ready_low", {31'b0, ready}, 32'h0);
        idle();
        begin
            int n = 6;
            while (n < 100 && !ready) begin
                tick();
                n++;
            end
            chk("clear_cycles", n, 31);
        end
        readaddr1 = 5'd29; readaddr2 = 5'd5;
        #1;
        chk("sp_init", readdata1, 32'h7fffeffc);
        chk("cleared_5", readdata2, 32'h0);
        readaddr1 = 5'd3;
        #1;
        chk("clear_write_ignored", readdata1, 32'h0);

        // Reset at clear index 10 restarts the whole sequence
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        chk("midclear_rst_ready", {31'b0, ready}, 32'h0);
        count_to_ready("midclear_restart_cycles");

        // Directed RUN-mode vectors
        for (int i = 0; i < 12; i++) begin
            we0 = tbl[i].we0; we1 = tbl[i].we1;
            writeaddr0 = tbl[i].wa0; writeaddr1 = tbl[i].wa1;
            writedata0 = tbl[i].wd0; writedata1 = tbl[i].wd1;
            readaddr1 = tbl[i].ra1; readaddr2 = tbl[i].ra2; io_in = tbl[i].ioin;
            @(negedge clk);
            chk($sformatf("vec%0d_rd1", i), readdata1, tbl[i].e_rd1);
            chk($sformatf("vec%0d_rd2", i), readdata2, tbl[i].e_rd2);
            tick();
            chk($sformatf("vec%0d_io_out", i), io_out, tbl[i].e_io);
            chk($sformatf("vec%0d_io_valid", i), {31'b0, io_out_valid}, {31'b0, tbl[i].e_iov});
        end

        // Randomized traffic, occasional resets
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
            writeaddr0 = rand_addr(); writeaddr1 = ($urandom_range(0, 3) == 0) ? writeaddr0 : rand_addr();
            writedata0 = $urandom(); writedata1 = $urandom(); io_in = $urandom();
            readaddr1 = ($urandom_range(0, 2) == 0) ? writeaddr0 : rand_addr();
            readaddr2 = ($urandom_range(0, 2) == 0) ? writeaddr1 : rand_addr();
            @(negedge clk);
            chk($sformatf("rnd%0d_rd1", i), readdata1, m_read(readaddr1));
            chk($sformatf("rnd%0d_rd2", i), readdata2, m_read(readaddr2));
            tick();
            chk($sformatf("rnd%0d_ready", i), {31'b0, ready}, {31'b0, m_clr_left == 0});
            chk($sformatf("rnd%0d_io_out", i), io_out, m_io);
            chk($sformatf("rnd%0d_io_valid", i), {31'b0, io_out_valid}, {31'b0, m_iov});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
